seq_chunk_adder: RTL and testbench

- Multi-cycle wide adder that feeds one narrow ripple_adder instance (width CHUNK) with successive operand slices, LSB slice first.
- Consumes each slice's sum and carry-out, and chains the registered carry into the next slice.
- Trades latency for area: a W-bit add runs on a CHUNK-bit carry chain.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.

---
 rtl/seq_chunk_adder.sv | 196 +++++++++++++++++++
 tb/tb_seq_chunk_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//
// Multi-cycle W-bit adder built on a single CHUNK-bit ripple adder. Operand
// slices are fed LSB first, one slice per clock. The carry between slices is
// held in a register, so no carry path runs combinationally from one slice to
// the next. Valid/ready handshakes are used on both the operand side and the
// result side.
//
// Optional feature macro: SEQ_CHUNK_ADDER_OVF_EN
//   When defined, adds output oOvf: the two's-complement signed overflow of
//   the W-bit add. It is registered with oS/oC and is valid with oValid.
//
// Ports:
//   iClk    in   1  clock, rising edge
//   iRstn   in   1  synchronous active-low reset
//   iValid  in   1  operand pair valid
//   oReady  out  1  block can accept an operand pair (IDLE only)
//   iA      in   W  operand A
//   iB      in   W  operand B
//   iC      in   1  carry-in
//   oValid  out  1  result valid (held until iReady)
//   iReady  in   1  downstream accepts result
//   oS      out  W  sum
//   oC      out  1  carry-out of the W-bit add
//   oOvf    out  1  signed overflow (only with SEQ_CHUNK_ADDER_OVF_EN)
// -----------------------------------------------------------------------------

// Narrow combinational ripple-carry adder used for one slice per cycle.
module ripple_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);
   logic [N:0] c_s;

   assign c_s[0] = ci;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s[i]     = a[i] ^ b[i] ^ c_s[i];
      assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
   end

   assign co = c_s[N];
endmodule

module seq_chunk_adder #(
   parameter int W     = 32,
   parameter int CHUNK = 8
) (
   input  logic         iClk,
   input  logic         iRstn,
   input  logic         iValid,
   output logic         oReady,
   input  logic [W-1:0] iA,
   input  logic [W-1:0] iB,
   input  logic         iC,
   output logic         oValid,
   input  logic         iReady,
   output logic [W-1:0] oS,
   output logic         oC
`ifdef SEQ_CHUNK_ADDER_OVF_EN
   ,
   output logic         oOvf
`endif
);
   localparam int NCHUNK = W / CHUNK;
   // A counter of at least one bit keeps NCHUNK=1 legal.
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_r;
   logic [W-1:0]      a_r;
   logic [W-1:0]      b_r;
   logic [W-1:0]      res_r;
   logic              carry_r;
   logic [CW-1:0]     cnt_r;

   logic [CHUNK-1:0]  sum_s;
   logic              co_s;
   logic [W-1:0]      res_next_s;

   // Current slice: low bits of the operand shift registers plus the
   // registered carry from the previous slice.
   ripple_adder #(.N(CHUNK)) u_ripple (
      .a  (a_r[CHUNK-1:0]),
      .b  (b_r[CHUNK-1:0]),
      .ci (carry_r),
      .s  (sum_s),
      .co (co_s)
   );

   // Result register with the new slice sum shifted in at the MSB end; after
   // NCHUNK shifts the first slice has reached bit 0.
   if (NCHUNK == 1) begin : g_res_single
      assign res_next_s = sum_s;
   end else begin : g_res_multi
      assign res_next_s = {sum_s, res_r[W-1:CHUNK]};
   end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
   logic ovf_s;

   // Carry into the MSB is recovered from the MSB sum bit; overflow is that
   // carry XOR the carry out of the MSB, both from the final slice.
   assign ovf_s = (a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ sum_s[CHUNK-1]) ^ co_s;
`endif

   // Control FSM, slice datapath and registered handshake/result outputs.
   always_ff @(posedge iClk) begin
      if (!iRstn) begin
         state_r <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         carry_r <= 1'b0;
         cnt_r   <= '0;
         oReady  <= 1'b1;
         oValid  <= 1'b0;
         oS      <= '0;
         oC      <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
         oOvf    <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (iValid) begin
                  a_r     <= iA;
                  b_r     <= iB;
                  carry_r <= iC;
                  cnt_r   <= '0;
                  state_r <= RUN;
                  oReady  <= 1'b0;
                  oValid  <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  oReady  <= 1'b1;
                  oValid  <= 1'b0;
               end
            end

            RUN: begin
               a_r     <= a_r >> CHUNK;
               b_r     <= b_r >> CHUNK;
               res_r   <= res_next_s;
               carry_r <= co_s;
               cnt_r   <= cnt_r + 1'b1;
               oReady  <= 1'b0;
               if (cnt_r == LAST_CNT) begin
                  state_r <= DONE;
                  oValid  <= 1'b1;
                  oS      <= res_next_s;
                  oC      <= co_s;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                  oOvf    <= ovf_s;
`endif
               end else begin
                  state_r <= RUN;
                  oValid  <= 1'b0;
               end
            end

            DONE: begin
               // Result held for as long as the consumer stalls; no new
               // operand is taken in the same cycle as the handoff.
               if (iReady) begin
                  state_r <= IDLE;
                  oValid  <= 1'b0;
                  oReady  <= 1'b1;
               end else begin
                  state_r <= DONE;
                  oValid  <= 1'b1;
                  oReady  <= 1'b0;
               end
            end

            default: begin
               state_r <= IDLE;
               oReady  <= 1'b1;
               oValid  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;
   logic        iClk;
   logic        iRstn;
   logic        iValid;
   logic        oReady;
   logic [31:0] iA;
   logic [31:0] iB;
   logic        iC;
   logic        oValid;
   logic        iReady;
   logic [31:0] oS;
   logic        oC;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
   logic        oOvf;
`endif

   int total;
   int bad;

   seq_chunk_adder #(.W(32), .CHUNK(8)) dut (
      .iClk   (iClk),
      .iRstn  (iRstn),
      .iValid (iValid),
      .oReady (oReady),
      .iA     (iA),
      .iB     (iB),
      .iC     (iC),
      .oValid (oValid),
      .iReady (iReady),
      .oS     (oS),
      .oC     (oC)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ,
      .oOvf   (oOvf)
`endif
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Accept an operand pair on the next edge (block must be in IDLE).
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic c);
      iA = a;
      iB = b;
      iC = c;
      iValid = 1'b1;
      tick();
      iValid = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      iRstn = 1'b0;
      iValid = 1'b0;
      iA = 32'h0;
      iB = 32'h0;
      iC = 1'b0;
      iReady = 1'b0;

      // Reset then idle
      tick();
      tick();
      iRstn = 1'b1;
      tick();
      check("rst_ready", {31'd0, oReady}, 32'd1);
      check("rst_valid", {31'd0, oValid}, 32'd0);
      check("rst_s", oS, 32'h0);
      check("rst_c", {31'd0, oC}, 32'd0);

      // Full carry ripple: exactly 4 cycles after accept
      iReady = 1'b1;
      start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      check("ripple_busy", {31'd0, oReady}, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         check("ripple_early_valid", {31'd0, oValid}, 32'd0);
         tick();
      end
      tick();
      check("ripple_valid", {31'd0, oValid}, 32'd1);
      check("ripple_s", oS, 32'h0000_0000);
      check("ripple_c", {31'd0, oC}, 32'd1);
      tick();
      check("ripple_drop", {31'd0, oValid}, 32'd0);
      check("ripple_idle_ready", {31'd0, oReady}, 32'd1);

      // Add with 5-cycle stall
      iReady = 1'b0;
      start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'd0, oValid}, 32'd1);
         check("stall_s", oS, 32'hACF1_3568);
         check("stall_c", {31'd0, oC}, 32'd0);
         check("stall_ready", {31'd0, oReady}, 32'd0);
         tick();
      end
      iReady = 1'b1;
      tick();
      check("stall_release_valid", {31'd0, oValid}, 32'd0);
      check("stall_release_ready", {31'd0, oReady}, 32'd1);

      // Busy ignore: iValid pulse during RUN does not disturb the result
      start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
      iA = 32'h1;
      iB = 32'h1;
      iValid = 1'b1;
      tick();
      tick();
      iValid = 1'b0;
      tick();
      tick();
      check("busy_valid", {31'd0, oValid}, 32'd1);
      check("busy_s", oS, 32'h0000_0100);
      check("busy_c", {31'd0, oC}, 32'd0);
      tick();
      check("busy_idle", {31'd0, oReady}, 32'd1);
      start_op(32'h0000_0001, 32'h0000_0001, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("next_valid", {31'd0, oValid}, 32'd1);
      check("next_s", oS, 32'h0000_0002);
      tick();

      // Mid-operation reset in 2nd RUN cycle
      start_op(32'h0000_0005, 32'h0000_0006, 1'b0);
      tick();
      iRstn = 1'b0;
      tick();
      iRstn = 1'b1;
      check("midrst_valid", {31'd0, oValid}, 32'd0);
      check("midrst_ready", {31'd0, oReady}, 32'd1);
      check("midrst_s", oS, 32'h0);
      check("midrst_c", {31'd0, oC}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("midrst_no_valid", {31'd0, oValid}, 32'd0);
      end

      // iValid together with reset: reset wins
      iA = 32'h0000_0003;
      iB = 32'h0000_0004;
      iValid = 1'b1;
      iRstn = 1'b0;
      tick();
      iValid = 1'b0;
      iRstn = 1'b1;
      tick();
      check("rstwin_ready", {31'd0, oReady}, 32'd1);
      check("rstwin_valid", {31'd0, oValid}, 32'd0);

      // Signed overflow cases
      start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("ovf1_valid", {31'd0, oValid}, 32'd1);
      check("ovf1_s", oS, 32'h8000_0000);
      check("ovf1_c", {31'd0, oC}, 32'd0);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      check("ovf1_ovf", {31'd0, oOvf}, 32'd1);
`endif
      tick();
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("ovf2_valid", {31'd0, oValid}, 32'd1);
      check("ovf2_s", oS, 32'h0000_0000);
      check("ovf2_c", {31'd0, oC}, 32'd1);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      check("ovf2_ovf", {31'd0, oOvf}, 32'd0);
`endif
      tick();

      // Mixed carry pattern with carry-in
      start_op(32'h80FF_00FF, 32'h8001_FF01, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      check("mix_valid", {31'd0, oValid}, 32'd1);
      check("mix_s", oS, 32'h0101_0001);
      check("mix_c", {31'd0, oC}, 32'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
